// File: rtl/clock_time_ctrl.sv
// Digital-clock sequencer: chained sec/min/hr counters with a RUN/SET_HR/SET_MIN mode FSM.
// Optional macro CLK_ADJ_DOWN_EN enables btn_down decrement of the selected field in SET modes.
module clock_time_ctrl #(
   parameter int SEC_MOD = 60,
   parameter int MIN_MOD = 60,
   parameter int HR_MOD  = 24
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       tick,
   input  logic                       btn_mode,
   input  logic                       btn_up,
   input  logic                       btn_down,
   output logic [$clog2(SEC_MOD)-1:0] sec,
   output logic [$clog2(MIN_MOD)-1:0] min,
   output logic [$clog2(HR_MOD)-1:0]  hr,
   output logic [1:0]                 mode,
   output logic                       day_pulse
);

   localparam int SEC_W = $clog2(SEC_MOD);
   localparam int MIN_W = $clog2(MIN_MOD);
   localparam int HR_W  = $clog2(HR_MOD);

   localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_MOD - 1);
   localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MIN_MOD - 1);
   localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(HR_MOD - 1);
   localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);
   localparam logic [MIN_W-1:0] MIN_ONE = MIN_W'(1);
   localparam logic [HR_W-1:0]  HR_ONE  = HR_W'(1);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } mode_t;

   mode_t             r_mode, w_mode_nxt;
   logic [SEC_W-1:0]  r_sec, w_sec_nxt;
   logic [MIN_W-1:0]  r_min, w_min_nxt;
   logic [HR_W-1:0]   r_hr, w_hr_nxt;
   logic              r_day, w_day_nxt;
   logic              w_up, w_dn;

   // btn_mode wins over adjust buttons; with down enabled, up+down together cancel
`ifdef CLK_ADJ_DOWN_EN
   assign w_up = btn_up & ~btn_down & ~btn_mode;
   assign w_dn = btn_down & ~btn_up & ~btn_mode;
`else
   logic w_unused_btn_down;
   assign w_unused_btn_down = btn_down;
   assign w_up = btn_up & ~btn_mode;
   assign w_dn = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mode <= RUN;
         r_sec  <= '0;
         r_min  <= '0;
         r_hr   <= '0;
         r_day  <= 1'b0;
      end else begin
         r_mode <= w_mode_nxt;
         r_sec  <= w_sec_nxt;
         r_min  <= w_min_nxt;
         r_hr   <= w_hr_nxt;
         r_day  <= w_day_nxt;
      end
   end

   always_comb begin
      w_mode_nxt = r_mode;
      case (r_mode)
         RUN:     if (btn_mode) w_mode_nxt = SET_HR;
         SET_HR:  if (btn_mode) w_mode_nxt = SET_MIN;
         SET_MIN: if (btn_mode) w_mode_nxt = RUN;
         default: w_mode_nxt = RUN;
      endcase
   end

   // Datapath decisions use the current mode, so a tick alongside the RUN-exit press still counts
   always_comb begin
      w_sec_nxt = r_sec;
      w_min_nxt = r_min;
      w_hr_nxt  = r_hr;
      w_day_nxt = 1'b0;
      case (r_mode)
         RUN: begin
            if (tick) begin
               if (r_sec == SEC_MAX) begin
                  w_sec_nxt = '0;
                  if (r_min == MIN_MAX) begin
                     w_min_nxt = '0;
                     if (r_hr == HR_MAX) begin
                        w_hr_nxt  = '0;
                        w_day_nxt = 1'b1;
                     end else begin
                        w_hr_nxt = r_hr + HR_ONE;
                     end
                  end else begin
                     w_min_nxt = r_min + MIN_ONE;
                  end
               end else begin
                  w_sec_nxt = r_sec + SEC_ONE;
               end
            end
         end
         SET_HR: begin
            if (w_up)
               w_hr_nxt = (r_hr == HR_MAX) ? '0 : r_hr + HR_ONE;
            else if (w_dn)
               w_hr_nxt = (r_hr == '0) ? HR_MAX : r_hr - HR_ONE;
         end
         SET_MIN: begin
            if (btn_mode)
               w_sec_nxt = '0;
            else if (w_up)
               w_min_nxt = (r_min == MIN_MAX) ? '0 : r_min + MIN_ONE;
            else if (w_dn)
               w_min_nxt = (r_min == '0) ? MIN_MAX : r_min - MIN_ONE;
         end
         default: ;
      endcase
   end

   assign sec       = r_sec;
   assign min       = r_min;
   assign hr        = r_hr;
   assign mode      = r_mode;
   assign day_pulse = r_day;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: time-of-day model in total seconds plus literal checkpoints.
module tb_clock_time_ctrl;

   localparam int SEC_MOD = 60;
   localparam int MIN_MOD = 60;
   localparam int HR_MOD  = 24;
   localparam int DAY_S   = SEC_MOD * MIN_MOD * HR_MOD;
`ifdef CLK_ADJ_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic [5:0] sec, min;
   logic [4:0] hr;
   logic [1:0] mode;
   logic       day_pulse;

   int n_chk = 0;
   int n_fail = 0;

   int m_sec = 0, m_min = 0, m_hr = 0, m_mode = 0, m_day = 0;

   clock_time_ctrl #(.SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD), .HR_MOD(HR_MOD)) dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .btn_mode(btn_mode),
      .btn_up(btn_up), .btn_down(btn_down), .sec(sec), .min(min), .hr(hr),
      .mode(mode), .day_pulse(day_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: time of day as seconds since midnight, adjusted by modular arithmetic
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_sec = 0; m_min = 0; m_hr = 0; m_mode = 0; m_day = 0;
      end else begin
         int  t;
         bit  up, dn;
         up = btn_up && !btn_mode && !(DOWN_EN && btn_down);
         dn = DOWN_EN && btn_down && !btn_mode && !btn_up;
         m_day = 0;
         if (m_mode == 0 && tick) begin
            t = ((m_hr * MIN_MOD + m_min) * SEC_MOD + m_sec + 1) % DAY_S;
            m_sec = t % SEC_MOD;
            m_min = (t / SEC_MOD) % MIN_MOD;
            m_hr  = t / (SEC_MOD * MIN_MOD);
            m_day = (t == 0);
         end else if (m_mode == 1) begin
            if (up) m_hr = (m_hr + 1) % HR_MOD;
            else if (dn) m_hr = (m_hr + HR_MOD - 1) % HR_MOD;
         end else if (m_mode == 2) begin
            if (btn_mode) m_sec = 0;
            else if (up) m_min = (m_min + 1) % MIN_MOD;
            else if (dn) m_min = (m_min + MIN_MOD - 1) % MIN_MOD;
         end
         if (btn_mode) m_mode = (m_mode + 1) % 3;
      end
   end

   always @(negedge clk) begin
      chk("sec", 32'(sec), m_sec);
      chk("min", 32'(min), m_min);
      chk("hr", 32'(hr), m_hr);
      chk("mode", 32'(mode), m_mode);
      chk("day_pulse", 32'(day_pulse), m_day);
   end

   task automatic cyc(input logic t, input logic bm, input logic bu, input logic bd);
      tick = t; btn_mode = bm; btn_up = bu; btn_down = bd;
      @(posedge clk);
      #1;
      tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sec", 32'(sec), 0);
      chk("rst_mode", 32'(mode), 0);
      chk("rst_day", 32'(day_pulse), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      repeat (59) cyc(1, 0, 0, 0);
      chk("lit_sec59", 32'(sec), 59);
      chk("lit_min0", 32'(min), 0);
      cyc(1, 0, 0, 0);
      chk("lit_sec_wrap", 32'(sec), 0);
      chk("lit_min1", 32'(min), 1);

      repeat (5) cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      chk("lit_tick_on_exit", 32'(sec), 6);
      chk("lit_mode_sethr", 32'(mode), 1);
      repeat (25) cyc(1, 0, 1, 0);
      chk("lit_hr_wrap", 32'(hr), 1);
      chk("lit_frozen_sec", 32'(sec), 6);
      chk("lit_frozen_min", 32'(min), 1);
      repeat (4) cyc(0, 0, 1, 0);
      cyc(0, 1, 1, 0);
      chk("lit_mode_setmin", 32'(mode), 2);
      chk("lit_hr_held", 32'(hr), 5);
      repeat (59) cyc(0, 0, 1, 0);
      chk("lit_min_wrap0", 32'(min), 0);
      cyc(0, 0, 0, 1);
      chk("lit_min_down", 32'(min), DOWN_EN ? 59 : 0);
      chk("lit_hr_nobrw", 32'(hr), 5);
      cyc(0, 0, 1, 1);
      cyc(0, 1, 0, 0);
      chk("lit_mode_run", 32'(mode), 0);
      chk("lit_sec_clr", 32'(sec), 0);

      // Set 23:59 then roll the day over
      cyc(0, 1, 0, 0);
      repeat (18) cyc(0, 0, 1, 0);
      chk("lit_hr23", 32'(hr), 23);
      cyc(0, 1, 0, 0);
      k = (59 - m_min + MIN_MOD) % MIN_MOD;
      repeat (k) cyc(0, 0, 1, 0);
      chk("lit_min59", 32'(min), 59);
      cyc(0, 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk("lit_sec1", 32'(sec), 1);
      repeat (58) cyc(1, 0, 0, 0);
      chk("lit_sec59b", 32'(sec), 59);
      cyc(1, 0, 0, 0);
      chk("lit_day_sec", 32'(sec), 0);
      chk("lit_day_min", 32'(min), 0);
      chk("lit_day_hr", 32'(hr), 0);
      chk("lit_day_pulse", 32'(day_pulse), 1);
      cyc(0, 0, 0, 0);
      chk("lit_day_drop", 32'(day_pulse), 0);

      // Reach 12:34:56 and assert reset between edges
      cyc(0, 1, 0, 0);
      repeat (12) cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      repeat (34) cyc(0, 0, 1, 0);
      cyc(0, 1, 0, 0);
      repeat (56) cyc(1, 0, 0, 0);
      chk("lit_hr12", 32'(hr), 12);
      chk("lit_min34", 32'(min), 34);
      chk("lit_sec56", 32'(sec), 56);
      cyc(0, 1, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_sec", 32'(sec), 0);
      chk("async_min", 32'(min), 0);
      chk("async_hr", 32'(hr), 0);
      chk("async_mode", 32'(mode), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) cyc(1, 0, 0, 0);
      chk("lit_post_rst", 32'(sec), 3);
      @(negedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
